// File: rtl/vec_mul_int_seq.sv
// Time-multiplexed, pipelined elementwise integer vector multiplier with valid/ready on both sides.
// Build macro VEC_MUL_INT_SEQ_SAT_EN: saturate (instead of wrap) when prd_width < 2*bit_width.
module vec_mul_int_seq #(
  parameter int bit_width   = 8,
  parameter int length      = 32,
  parameter int prd_width   = 2*bit_width,
  parameter int lanes       = 8,
  parameter int pipe_stages = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic                        i_signed,
  input  logic [bit_width*length-1:0] i_vec_a,
  input  logic [bit_width*length-1:0] i_vec_b,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [prd_width*length-1:0] o_prd
);

  localparam int beats = length / lanes;
  localparam int fw    = 2*bit_width + 2;
  localparam int cw    = $clog2(beats + 1);
  localparam int kw    = (beats > 1) ? $clog2(beats) : 1;
  localparam int ls    = pipe_stages - 1;

  if (length % lanes != 0) begin : g_len_chk
    $error("vec_mul_int_seq: length must be a multiple of lanes");
  end
  if (pipe_stages < 1) begin : g_pipe_chk
    $error("vec_mul_int_seq: pipe_stages must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                      state_q, state_d;
  logic [cw-1:0]               cnt_q;
  logic [bit_width*length-1:0] a_cap, b_cap;
  logic                        mode_cap;

  logic                        issue_p0;
  logic [kw-1:0]               tag_p0;
  logic signed [fw-1:0]        prd_p0 [lanes];

  logic signed [fw-1:0]        prd_p [pipe_stages][lanes];
  logic [kw-1:0]               tag_p [pipe_stages];
  logic                        vld_p [pipe_stages];
  logic                        last_wr;

  // Exact product: operands widened by their sign bit (signed mode) or zeros (unsigned mode).
  function automatic logic signed [fw-1:0] mul_ext(input logic [bit_width-1:0] a,
                                                   input logic [bit_width-1:0] b,
                                                   input logic             sgn);
    logic signed [fw-1:0] ax, bx;
    ax = {{(fw-bit_width){sgn & a[bit_width-1]}}, a};
    bx = {{(fw-bit_width){sgn & b[bit_width-1]}}, b};
    return ax * bx;
  endfunction

`ifdef VEC_MUL_INT_SEQ_SAT_EN
  localparam logic signed [fw-1:0] smax = (fw'(1) <<< (prd_width-1)) - fw'(1);
  localparam logic signed [fw-1:0] smin = -smax - fw'(1);
  localparam logic signed [fw-1:0] umax = (fw'(1) <<< prd_width) - fw'(1);
`endif

  // The full product is always a true signed value, so a signed cast extends or wraps correctly in both modes.
  function automatic logic [prd_width-1:0] narrow(input logic signed [fw-1:0] p,
                                                  input logic             sgn);
    logic [prd_width-1:0] r;
    r = prd_width'(p);
`ifdef VEC_MUL_INT_SEQ_SAT_EN
    if (prd_width < 2*bit_width) begin
      if (sgn) begin
        if (p > smax)      r = prd_width'(smax);
        else if (p < smin) r = prd_width'(smin);
      end else if (p > umax) begin
        r = prd_width'(umax);
      end
    end
`endif
    return r;
  endfunction

  // Stage p0: select beat k of the captured operands and multiply
  always_comb begin
    issue_p0 = (state_q == BUSY) && (cnt_q < cw'(beats));
    tag_p0   = kw'(cnt_q);
    for (int l = 0; l < lanes; l++) begin
      prd_p0[l] = mul_ext(a_cap[(int'(cnt_q)*lanes + l)*bit_width +: bit_width],
                          b_cap[(int'(cnt_q)*lanes + l)*bit_width +: bit_width],
                          mode_cap);
    end
  end

  // Stages p1..pN: multiplier pipeline carrying beat tag and valid
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < pipe_stages; s++) begin
        vld_p[s] <= 1'b0;
        tag_p[s] <= '0;
        for (int l = 0; l < lanes; l++) prd_p[s][l] <= '0;
      end
    end else begin
      vld_p[0] <= issue_p0;
      tag_p[0] <= tag_p0;
      prd_p[0] <= prd_p0;
      for (int s = 1; s < pipe_stages; s++) begin
        vld_p[s] <= vld_p[s-1];
        tag_p[s] <= tag_p[s-1];
        prd_p[s] <= prd_p[s-1];
      end
    end
  end

  assign last_wr = vld_p[ls] && (tag_p[ls] == kw'(beats - 1));

  // Output stage: capture, beat counter and result slice write-back
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q    <= '0;
      a_cap    <= '0;
      b_cap    <= '0;
      mode_cap <= 1'b0;
      o_prd    <= '0;
    end else begin
      if (state_q == IDLE && i_valid) begin
        a_cap    <= i_vec_a;
        b_cap    <= i_vec_b;
        mode_cap <= i_signed;
        cnt_q    <= '0;
      end else if (issue_p0) begin
        cnt_q <= cnt_q + cw'(1);
      end
      if (vld_p[ls]) begin
        for (int l = 0; l < lanes; l++) begin
          o_prd[(int'(tag_p[ls])*lanes + l)*prd_width +: prd_width] <= narrow(prd_p[ls][l], mode_cap);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_d = BUSY;
      end
      BUSY: if (last_wr) state_d = DONE;
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
